// File: rtl/sdf_bf_stage_p.sv
// Radix-2^2 single-path delay-feedback butterfly stage (BF-I or BF-II with -j rotation).
// Streams one complex sample per advance; supports stalls, flush, scaling and saturation.
module sdf_bf_stage_p #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int FRAME = 256,
    parameter int MODE  = 0,
    parameter int SCALE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             flush,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             ovf
);
    localparam int L = $clog2(DEPTH);
    localparam int F = $clog2(FRAME);
    localparam logic [L:0] FULL = (L+1)'(DEPTH);

    logic [F-1:0]     in_cnt;
    logic [F-1:0]     out_cnt;
    logic [L:0]       pend;
    logic [WIDTH-1:0] dl_re [DEPTH];
    logic [WIDTH-1:0] dl_im [DEPTH];

    logic             accept, flush_adv, adv, emit, bf, rot_phase, rotate, hit;
    logic [L-1:0]     ptr;
    logic [WIDTH-1:0] x0_re, x0_im, x1_re, x1_im;
    logic [WIDTH-1:0] sp_re, sp_im, dw_re, dw_im;
    logic [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
    logic [WIDTH:0]   y0_re, y0_im, y1_re, y1_im, neg_re, neg_sat;

    // Returns {clamped, value}: saturates a WIDTH+1 bit result into WIDTH bits.
    function automatic logic [WIDTH:0] clamp(input logic [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1])
            return {1'b1, s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    function automatic logic [WIDTH:0] bfly(input logic [WIDTH:0] s);
        logic [WIDTH+1:0] r;
        if (SCALE != 0) begin
            r = {s[WIDTH], s} + (WIDTH+2)'(1);
            return clamp((WIDTH+1)'($signed(r) >>> 1));
        end
        return clamp(s);
    endfunction

    assign accept    = di_en & ~clear;
    assign flush_adv = flush & ~di_en & ~clear & (pend != '0);
    assign adv       = accept | flush_adv;
    assign emit      = flush_adv | (accept & (pend == FULL));
    assign bf        = in_cnt[L];
    assign ptr       = in_cnt[L-1:0];

    assign x0_re = dl_re[ptr];
    assign x0_im = dl_im[ptr];
    assign x1_re = di_en ? di_re : '0;
    assign x1_im = di_en ? di_im : '0;

    assign sum_re = {x0_re[WIDTH-1], x0_re} + {x1_re[WIDTH-1], x1_re};
    assign sum_im = {x0_im[WIDTH-1], x0_im} + {x1_im[WIDTH-1], x1_im};
    assign dif_re = {x0_re[WIDTH-1], x0_re} - {x1_re[WIDTH-1], x1_re};
    assign dif_im = {x0_im[WIDTH-1], x0_im} - {x1_im[WIDTH-1], x1_im};
    assign y0_re  = bfly(sum_re);
    assign y0_im  = bfly(sum_im);
    assign y1_re  = bfly(dif_re);
    assign y1_im  = bfly(dif_im);
    assign neg_re  = '0 - {x0_re[WIDTH-1], x0_re};
    assign neg_sat = clamp(neg_re);

    // Last quarter of each 4*DEPTH output block carries the -j twiddle.
    if (MODE != 0) begin : g_rot
        assign rot_phase = (out_cnt[L+1:L] == 2'b11);
    end else begin : g_no_rot
        assign rot_phase = 1'b0;
    end
    assign rotate = rot_phase & ~bf;

    always_comb begin
        // NOTE: every output gets a default before the branches, so no latch is inferred.
        sp_re = x0_re;
        sp_im = x0_im;
        dw_re = x1_re;
        dw_im = x1_im;
        hit   = 1'b0;
        if (bf) begin
            sp_re = y0_re[WIDTH-1:0];
            sp_im = y0_im[WIDTH-1:0];
            dw_re = y1_re[WIDTH-1:0];
            dw_im = y1_im[WIDTH-1:0];
            hit   = y0_re[WIDTH] | y0_im[WIDTH] | y1_re[WIDTH] | y1_im[WIDTH];
        end else if (rotate) begin
            sp_re = x0_im;
            sp_im = neg_sat[WIDTH-1:0];
            hit   = neg_sat[WIDTH];
        end
    end

    // NOTE: the delay line is plain storage with no reset; unwritten slots are never emitted.
    always_ff @(posedge clock) begin
        if (adv) begin
            dl_re[ptr] <= dw_re;
            dl_im[ptr] <= dw_im;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            pend    <= '0;
            do_en   <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            ovf     <= 1'b0;
        end else if (clear) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            pend    <= '0;
            do_en   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            do_en <= emit;
            if (adv)
                in_cnt <= in_cnt + F'(1);
            if (emit) begin
                out_cnt <= out_cnt + F'(1);
                do_re   <= sp_re;
                do_im   <= sp_im;
            end
            if (accept && pend != FULL)
                pend <= pend + (L+1)'(1);
            else if (flush_adv)
                pend <= pend - (L+1)'(1);
            if (adv && hit && (bf || emit))
                ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdf_bf_stage_p.sv
// Bench for sdf_bf_stage_p: three instances (BF-I, BF-II, BF-I scaled) share one stimulus;
// a block-based model pushes expected outputs to per-instance queues popped on do_en.
module tb_sdf_bf_stage_p;
    localparam int D  = 4;
    localparam int FR = 16;
    localparam int MODE_C  [3] = '{0, 1, 0};
    localparam int SCALE_C [3] = '{0, 0, 1};

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    logic        clock, reset_n, clear, flush, di_en;
    logic [15:0] di_re, di_im;
    logic        do_en_w [3];
    logic [15:0] do_re_w [3];
    logic [15:0] do_im_w [3];
    logic        ovf_w   [3];

    sdf_bf_stage_p #(.WIDTH(16), .DEPTH(D), .FRAME(FR), .MODE(0), .SCALE(0)) u0 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .flush(flush), .di_en(di_en),
        .di_re(di_re), .di_im(di_im), .do_en(do_en_w[0]), .do_re(do_re_w[0]),
        .do_im(do_im_w[0]), .ovf(ovf_w[0]));
    sdf_bf_stage_p #(.WIDTH(16), .DEPTH(D), .FRAME(FR), .MODE(1), .SCALE(0)) u1 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .flush(flush), .di_en(di_en),
        .di_re(di_re), .di_im(di_im), .do_en(do_en_w[1]), .do_re(do_re_w[1]),
        .do_im(do_im_w[1]), .ovf(ovf_w[1]));
    sdf_bf_stage_p #(.WIDTH(16), .DEPTH(D), .FRAME(FR), .MODE(0), .SCALE(1)) u2 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .flush(flush), .di_en(di_en),
        .di_re(di_re), .di_im(di_im), .do_en(do_en_w[2]), .do_re(do_re_w[2]),
        .do_im(do_im_w[2]), .ovf(ovf_w[2]));

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    arm_cyc  = 0;
    int    first_out = -1;
    int    pos, oc;
    bit    ovf_m [3];
    cplx_t hold  [D];
    cplx_t expq  [3][$];
    cplx_t pdq   [3][$];
    cplx_t mon_e;
    int    t5_re [8] = '{3, 3, -3, -3, 0, 0, 0, 0};
    int    t5_im [8] = '{1, -1, 5, -5, 2, 2, 2, 2};

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Butterfly arithmetic in plain integers: optional round-half-up halving, then clamp.
    function automatic int fitb(input int s, input int sc);
        int v = (sc != 0) ? ((s + 1) >>> 1) : s;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit clips(input int s, input int sc);
        int v = (sc != 0) ? ((s + 1) >>> 1) : s;
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic model_emit(input int c, input cplx_t v, input bit is_diff);
        cplx_t o = v;
        int    n;
        if (MODE_C[c] != 0 && is_diff && ((oc / D) % 4) == 3) begin
            n    = -int'(v.re);
            o.re = v.im;
            o.im = 16'(fitb(n, 0));
            if (clips(n, 0)) ovf_m[c] = 1'b1;
        end
        expq[c].push_back(o);
    endtask

    task automatic model_accept(input logic signed [15:0] re, input logic signed [15:0] im);
        cplx_t a, s, d;
        int    sr, si, dr, dm;
        bit    emitted = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (pos < D) begin
                if (pdq[c].size() > 0) begin
                    model_emit(c, pdq[c].pop_front(), 1'b1);
                    emitted = 1'b1;
                end
            end else begin
                a  = hold[pos - D];
                sr = int'(a.re) + int'(re);
                si = int'(a.im) + int'(im);
                dr = int'(a.re) - int'(re);
                dm = int'(a.im) - int'(im);
                s.re = 16'(fitb(sr, SCALE_C[c]));
                s.im = 16'(fitb(si, SCALE_C[c]));
                d.re = 16'(fitb(dr, SCALE_C[c]));
                d.im = 16'(fitb(dm, SCALE_C[c]));
                if (clips(sr, SCALE_C[c]) || clips(si, SCALE_C[c]) ||
                    clips(dr, SCALE_C[c]) || clips(dm, SCALE_C[c]))
                    ovf_m[c] = 1'b1;
                model_emit(c, s, 1'b0);
                pdq[c].push_back(d);
                emitted = 1'b1;
            end
        end
        if (pos < D) begin
            hold[pos].re = re;
            hold[pos].im = im;
        end
        if (emitted) oc = (oc + 1) % FR;
        pos = (pos + 1) % (2 * D);
    endtask

    task automatic model_flush();
        bit emitted = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (pdq[c].size() > 0) begin
                model_emit(c, pdq[c].pop_front(), 1'b1);
                emitted = 1'b1;
            end
        end
        if (emitted) begin
            oc  = (oc + 1) % FR;
            pos = (pos + 1) % (2 * D);
        end
    endtask

    task automatic model_clear();
        pos = 0;
        oc  = 0;
        for (int c = 0; c < 3; c++) begin
            pdq[c].delete();
            ovf_m[c] = 1'b0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int c = 0; c < 3; c++) expq[c].delete();
    endtask

    task automatic step(input bit en, input bit fl, input bit cl,
                        input logic [15:0] re, input logic [15:0] im);
        @(negedge clock);
        di_en = en;
        flush = fl;
        clear = cl;
        di_re = re;
        di_im = im;
        if (cl) model_clear();
        else if (en) model_accept(re, im);
        else if (fl) model_flush();
    endtask

    task automatic feed_t1(input bit stall);
        int n = 0;
        for (int k = 1; k <= 16; k++) begin
            if (stall && (n % 3 == 2)) begin
                step(1'b0, 1'b0, 1'b0, 16'hdead, 16'hbeef);
                n++;
            end
            step(1'b1, 1'b0, 1'b0, 16'(k), 16'h0000);
            if (k == 1) arm_cyc = cyc;
            n++;
        end
    endtask

    // Flush, confirm every expected output appeared, compare ovf, then clear with a dropped sample.
    task automatic end_test(input string name);
        repeat (D + 2) step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s_drained_u%0d", name, c), expq[c].size(), 0);
            check($sformatf("%s_ovf_u%0d", name, c), int'(ovf_w[c]), int'(ovf_m[c]));
        end
        step(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_ovf_clr_u%0d", name, c), int'(ovf_w[c]), 0);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            for (int c = 0; c < 3; c++) begin
                if (do_en_w[c]) begin
                    if (c == 0 && first_out < 0) first_out = cyc;
                    if (expq[c].size() == 0) begin
                        check($sformatf("u%0d_extra_output", c), 1, 0);
                    end else begin
                        mon_e = expq[c].pop_front();
                        check($sformatf("u%0d_re", c), int'($signed(do_re_w[c])), int'(mon_e.re));
                        check($sformatf("u%0d_im", c), int'($signed(do_im_w[c])), int'(mon_e.im));
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        flush   = 1'b0;
        di_en   = 1'b0;
        di_re   = '0;
        di_im   = '0;
        model_reset();
        repeat (2) @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_do_en_u%0d", c), int'(do_en_w[c]), 0);
            check($sformatf("rst_do_re_u%0d", c), int'(do_re_w[c]), 0);
            check($sformatf("rst_do_im_u%0d", c), int'(do_im_w[c]), 0);
            check($sformatf("rst_ovf_u%0d", c), int'(ovf_w[c]), 0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // T1: ramp 1..16, also gives the (0,4) rotated tail on the BF-II instance.
        first_out = -1;
        feed_t1(1'b0);
        check("t1_latency", first_out - arm_cyc, 5);
        end_test("t1");

        // T2: same ramp with a stall every third cycle.
        feed_t1(1'b1);
        end_test("t2");

        // T3: constant 3+1j.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 16'd3, 16'd1);
        end_test("t3");

        // T4a: sum and difference saturation.
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 1'b0, (k < 6) ? 16'h7fff : 16'h8001, 16'h0000);
        end_test("t4a");

        // T4b: rotation of a -32768 real difference.
        for (int k = 0; k < 16; k++)
            step(1'b1, 1'b0, 1'b0, (k >= 8 && k < 12) ? 16'h8000 : 16'h0000, 16'h0000);
        end_test("t4b");

        // T5: rounding of odd sums/differences when scaling.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 16'(t5_re[k]), 16'(t5_im[k]));
        end_test("t5");

        // Random frames.
        for (int k = 0; k < 32; k++)
            step(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        end_test("rnd");

        // T6: back-to-back frames, reset mid-frame 2, then a clean T1 run.
        for (int k = 0; k < 23; k++)
            step(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        #2;
        reset_n = 1'b0;
        di_en   = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t6_rst_do_en_u%0d", c), int'(do_en_w[c]), 0);
            check($sformatf("t6_rst_do_re_u%0d", c), int'(do_re_w[c]), 0);
            check($sformatf("t6_rst_ovf_u%0d", c), int'(ovf_w[c]), 0);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        feed_t1(1'b0);
        end_test("t6");

        for (int c = 0; c < 3; c++)
            check($sformatf("final_queue_u%0d", c), expq[c].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
